// File: rtl/i2s_pkg.sv
// Shared I2S types and constants for the receive path.
package i2s_pkg;

   localparam int unsigned BITCNT_W      = 6;
   localparam int unsigned BCK_MIN_RATIO = 4;

   typedef enum logic {HUNT, RUN} rx_state_e;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// Two-flop synchroniser with a rising-edge detect taken from the synced stage.
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise_c
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic dly_q,  dly_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      dly_d  = sync_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         dly_q  <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   end

   assign dout   = sync_q;
   assign rise_c = sync_q & ~dly_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples BCK/LRCK/DATA, deserialises MSB-first words and
// emits one left/right pair per frame with a single-cycle valid strobe.
module i2s_rx
   import i2s_pkg::*;
#(
   parameter int unsigned AUDIO_DW = 16,
   parameter int unsigned TIMEOUT  = 4096
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic                i2s_bck,
   input  logic                i2s_lrck,
   input  logic                i2s_data,
   output logic [AUDIO_DW-1:0] left_chan,
   output logic [AUDIO_DW-1:0] right_chan,
   output logic                sample_valid,
   output logic                locked
);

   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
   localparam logic [IDLE_W-1:0]   IDLE_MAX   = IDLE_W'(TIMEOUT - 1);
   localparam logic [BITCNT_W-1:0] BITCNT_MAX = '1;

   logic bck_s, bck_rise, lrck_s, data_s;
   logic lrck_rise_unused, data_rise_unused;

   sync_edge u_sync_bck  (.clk(clk_sys), .rst(reset), .din(i2s_bck),  .dout(bck_s),  .rise_c(bck_rise));
   sync_edge u_sync_lrck (.clk(clk_sys), .rst(reset), .din(i2s_lrck), .dout(lrck_s), .rise_c(lrck_rise_unused));
   sync_edge u_sync_data (.clk(clk_sys), .rst(reset), .din(i2s_data), .dout(data_s), .rise_c(data_rise_unused));

   rx_state_e             state_q, state_d;
   logic                  lrck_prev_q, lrck_prev_d;
   logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
   logic [AUDIO_DW-1:0]   word_q, word_d, word_wr;
   logic                  have_left_q, have_left_d;
   logic [IDLE_W-1:0]     idle_q, idle_d;
   logic [AUDIO_DW-1:0]   left_q, left_d, right_q, right_d;
   logic                  valid_q, valid_d;
   logic                  locked_q, locked_d;

   // Bit capture, word-boundary commit and BCK-loss timeout.
   always_comb begin
      state_d     = state_q;
      lrck_prev_d = lrck_prev_q;
      bitcnt_d    = bitcnt_q;
      word_d      = word_q;
      have_left_d = have_left_q;
      idle_d      = idle_q;
      left_d      = left_q;
      right_d     = right_q;
      valid_d     = 1'b0;
      locked_d    = locked_q;
      word_wr     = word_q;

      if (bck_rise) begin
         idle_d = '0;
         // Bits past AUDIO_DW match no index and are dropped.
         for (int i = 0; i < int'(AUDIO_DW); i++) begin
            if (int'(bitcnt_q) == int'(AUDIO_DW) - 1 - i) word_wr[i] = data_s;
         end
         word_d = word_wr;
         if (bitcnt_q != BITCNT_MAX) bitcnt_d = bitcnt_q + BITCNT_W'(1);

         if (lrck_s != lrck_prev_q) begin
            lrck_prev_d = lrck_s;
            word_d      = '0;
            bitcnt_d    = '0;
            if (state_q == HUNT) begin
               state_d = RUN;
            end else if (!lrck_prev_q) begin
               left_d      = word_wr;
               have_left_d = 1'b1;
            end else begin
               right_d = word_wr;
               if (have_left_q) begin
                  valid_d     = 1'b1;
                  have_left_d = 1'b0;
                  locked_d    = 1'b1;
               end
            end
         end
      end else if (idle_q == IDLE_MAX) begin
         state_d     = HUNT;
         locked_d    = 1'b0;
         have_left_d = 1'b0;
      end else begin
         idle_d = idle_q + IDLE_W'(1);
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q     <= HUNT;
         lrck_prev_q <= 1'b0;
         bitcnt_q    <= '0;
         word_q      <= '0;
         have_left_q <= 1'b0;
         idle_q      <= '0;
         left_q      <= '0;
         right_q     <= '0;
         valid_q     <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         lrck_prev_q <= lrck_prev_d;
         bitcnt_q    <= bitcnt_d;
         word_q      <= word_d;
         have_left_q <= have_left_d;
         idle_q      <= idle_d;
         left_q      <= left_d;
         right_q     <= right_d;
         valid_q     <= valid_d;
         locked_q    <= locked_d;
      end
   end

   assign left_chan    = left_q;
   assign right_chan   = right_q;
   assign sample_valid = valid_q;
   assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: an I2S source model drives frames of varying
// word length; received pairs are compared against MSB-aligned expected words.
module tb_i2s_rx;

   localparam int unsigned DW  = 16;
   localparam int unsigned TMO = 4096;

   logic          clk_sys = 1'b0;
   logic          reset;
   logic          i2s_bck, i2s_lrck, i2s_data;
   logic [DW-1:0] left_chan, right_chan;
   logic          sample_valid, locked;

   i2s_rx #(.AUDIO_DW(DW), .TIMEOUT(TMO)) dut (
      .clk_sys     (clk_sys),
      .reset       (reset),
      .i2s_bck     (i2s_bck),
      .i2s_lrck    (i2s_lrck),
      .i2s_data    (i2s_data),
      .left_chan   (left_chan),
      .right_chan  (right_chan),
      .sample_valid(sample_valid),
      .locked      (locked)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] obs_l[$], obs_r[$], exp_l[$], exp_r[$];
   int            obs_lat[$];
   int            cyc = 0;
   int            rise_cyc = 0;
   logic          bck_prev = 1'b0;
   logic          last_bit = 1'b0;
   bit            jitter = 1'b0;

   // Track the clk_sys edge on which each BCK pin rise is first seen.
   always @(posedge clk_sys) begin
      cyc = cyc + 1;
      if (i2s_bck === 1'b1 && bck_prev === 1'b0) rise_cyc = cyc;
      bck_prev = i2s_bck;
   end

   // Capture every strobe with its latency relative to the causing BCK rise.
   always @(negedge clk_sys) begin
      if (sample_valid === 1'b1) begin
         obs_l.push_back(left_chan);
         obs_r.push_back(right_chan);
         obs_lat.push_back(cyc - rise_cyc + 1);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // An n-bit word left-aligned into DW bits: truncate long words, zero-fill short ones.
   function automatic logic [DW-1:0] fit(input logic [31:0] w, input int n);
      logic [63:0] x;
      x = 64'(w) << (64 - n);
      return x[63 -: DW];
   endfunction

   function automatic int half_len();
      return jitter ? int'($urandom_range(5, 3)) : 4;
   endfunction

   task automatic send_period(input logic lr, input logic d);
      i2s_bck  = 1'b0;
      i2s_lrck = lr;
      i2s_data = d;
      repeat (half_len()) @(negedge clk_sys);
      i2s_bck = 1'b1;
      repeat (half_len()) @(negedge clk_sys);
   endtask

   // One channel slot: first period carries the previous word's LSB.
   task automatic send_half(input logic c, input logic [31:0] w, input int n);
      for (int j = 0; j < n; j++) send_period(c, (j == 0) ? last_bit : w[n - j]);
      last_bit = w[0];
   endtask

   task automatic run_phase(input string name, input int nfr, input int n,
                            input bit lfix_en, input logic [31:0] lfix,
                            input bit rfix_en, input logic [31:0] rfix,
                            input int nfix, input bit first_check);
      logic [31:0] mask, lw, rw;
      mask = (32'd1 << n) - 32'd1;
      obs_l.delete(); obs_r.delete(); obs_lat.delete();
      exp_l.delete(); exp_r.delete();
      for (int i = 0; i < nfr; i++) begin
         lw = (lfix_en && i < nfix) ? lfix : ($urandom & mask);
         rw = (rfix_en && i < nfix) ? rfix : ($urandom & mask);
         send_half(1'b0, lw, n);
         send_half(1'b1, rw, n);
         if (i > 0) begin
            exp_l.push_back(fit(lw, n));
            exp_r.push_back(fit(rw, n));
         end
         if (first_check && i == 0) begin
            repeat (4) @(negedge clk_sys);
            check({name, "_first_pulses"}, 32'(obs_l.size()), 32'd0);
            check({name, "_first_left"},   32'(left_chan),    32'd0);
            check({name, "_first_right"},  32'(right_chan),   32'd0);
         end
      end
      send_half(1'b0, 32'd0, n);
      repeat (4) @(negedge clk_sys);
      check({name, "_pulses"}, 32'(obs_l.size()), 32'(nfr - 1));
      check({name, "_locked"}, 32'(locked), 32'd1);
      for (int k = 0; k < exp_l.size() && k < obs_l.size(); k++) begin
         check($sformatf("%s_left%0d", name, k),    32'(obs_l[k]),   32'(exp_l[k]));
         check($sformatf("%s_right%0d", name, k),   32'(obs_r[k]),   32'(exp_r[k]));
         check($sformatf("%s_latency%0d", name, k), 32'(obs_lat[k]), 32'd3);
      end
      i2s_bck = 1'b0;
      repeat (TMO + 16) @(negedge clk_sys);
      check({name, "_timeout_unlock"}, 32'(locked), 32'd0);
      if (exp_l.size() > 0)
         check({name, "_hold_left"}, 32'(left_chan), 32'(exp_l[exp_l.size() - 1]));
   endtask

   initial begin
      reset    = 1'b1;
      i2s_bck  = 1'b0;
      i2s_lrck = 1'b0;
      i2s_data = 1'b0;
      repeat (4) @(negedge clk_sys);
      check("rst_left",   32'(left_chan),    32'd0);
      check("rst_right",  32'(right_chan),   32'd0);
      check("rst_valid",  32'(sample_valid), 32'd0);
      check("rst_locked", 32'(locked),       32'd0);
      reset = 1'b0;
      repeat (4) @(negedge clk_sys);

      run_phase("w16", 6, 16, 1'b1, 32'h8001, 1'b1, 32'h7FFE, 3, 1'b0);
      run_phase("w24", 3, 24, 1'b1, 32'hABCDEF, 1'b0, 32'd0, 3, 1'b0);
      run_phase("w8",  3, 8,  1'b0, 32'd0, 1'b1, 32'h5A, 3, 1'b0);

      jitter = 1'b1;
      run_phase("jit", 5, 16, 1'b0, 32'd0, 1'b0, 32'd0, 0, 1'b0);
      jitter = 1'b0;

      // Abort a left word part way through with reset.
      for (int j = 0; j < 8; j++) send_period(1'b0, 1'($urandom));
      reset = 1'b1;
      repeat (3) @(negedge clk_sys);
      i2s_bck = 1'b0;
      check("midrst_left",   32'(left_chan),  32'd0);
      check("midrst_right",  32'(right_chan), 32'd0);
      check("midrst_locked", 32'(locked),     32'd0);
      repeat (2) @(negedge clk_sys);
      reset = 1'b0;
      repeat (4) @(negedge clk_sys);
      run_phase("rst", 2, 16, 1'b0, 32'd0, 1'b0, 32'd0, 0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
